memc_deskew: RTL and testbench

//  Output-side counterpart of the A-operand skew FIFOs. Collects results leaving the bottom

---
 rtl/memc_deskew.sv | 152 +++++++++++++++
 tb/tb_memc_deskew.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memc_deskew.sv
// Output deskew for the systolic MAC array: realigns skewed result rows, tags them
// with a wrapping sequence number and buffers them in a first-word fall-through FIFO.
module memc_deskew #(
  parameter int BITS_C = 16,
  parameter int DIM    = 8,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic [DIM-1:0][BITS_C-1:0]    Cin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DIM-1:0][BITS_C-1:0]    Cout,
  output logic [$clog2(DIM)-1:0]        out_row,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow
);

  localparam int TW = $clog2(DIM);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DIM-2:0]                r_vld;
  logic [DIM-1:0][BITS_C-1:0]    w_row;
  logic                          w_al_valid;
  logic                          w_pop;
  logic                          w_push_ok;
  logic                          w_drop;

  logic [DIM-1:0][BITS_C-1:0]    r_mem [DEPTH];
  logic [TW-1:0]                 r_mem_tag [DEPTH];
  logic [PW-1:0]                 r_wptr;
  logic [PW-1:0]                 r_rptr;
  logic [CW-1:0]                 r_count;
  logic [TW-1:0]                 r_tag;
  logic                          r_overflow;

  // Valid delay line: DIM-1 stages, flushed by clr so in-flight rows vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (clr) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= in_valid;
      for (int k = 1; k < DIM-1; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  // Column j waits DIM-1-j cycles so every column lands on the same edge.
  for (genvar j = 0; j < DIM-1; j++) begin : g_col
    localparam int NS = DIM - 1 - j;
    logic [BITS_C-1:0] r_col [NS];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < NS; k++) begin
          r_col[k] <= '0;
        end
      end else begin
        r_col[0] <= Cin[j];
        for (int k = 1; k < NS; k++) begin
          r_col[k] <= r_col[k-1];
        end
      end
    end

    assign w_row[j] = r_col[NS-1];
  end

  assign w_row[DIM-1] = Cin[DIM-1];
  assign w_al_valid   = r_vld[DIM-2];

  // Push/pop decisions; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    w_pop     = 1'b0;
    w_push_ok = 1'b0;
    w_drop    = 1'b0;
    if (clr) begin
      w_pop     = 1'b0;
      w_push_ok = 1'b0;
      w_drop    = 1'b0;
    end else begin
      w_pop = (r_count != '0) && out_ready;
      if (w_al_valid && ((r_count < CW'(DEPTH)) || w_pop)) begin
        w_push_ok = 1'b1;
      end else begin
        w_drop = w_al_valid;
      end
    end
  end

  // FIFO storage; data is not flushed by clr since pointers and count define validity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k]     <= '0;
        r_mem_tag[k] <= '0;
      end
    end else if (w_push_ok) begin
      r_mem[r_wptr]     <= w_row;
      r_mem_tag[r_wptr] <= r_tag;
    end
  end

  // Pointers, occupancy, tag counter and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_tag      <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_tag      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Dropped rows still consume a tag so the host can see the gap.
      if (w_al_valid) begin
        r_tag <= (r_tag == TW'(DIM-1)) ? '0 : r_tag + TW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_valid = (r_count != '0);
  assign Cout      = r_mem[r_rptr];
  assign out_row   = r_mem_tag[r_rptr];
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_memc_deskew.sv
// Directed self-checking bench for memc_deskew (DIM=8, DEPTH=4, BITS_C=16).
module tb_memc_deskew;
  localparam int BITS_C = 16;
  localparam int DIM    = 8;
  localparam int DEPTH  = 4;
  localparam int NCYC   = 64;

  logic                       clk;
  logic                       rst_n;
  logic                       clr;
  logic                       in_valid;
  logic                       out_ready;
  logic                       out_valid;
  logic                       overflow;
  logic [DIM-1:0][BITS_C-1:0] Cin;
  logic [DIM-1:0][BITS_C-1:0] Cout;
  logic [DIM-1:0][BITS_C-1:0] exp_row;
  logic [2:0]                 out_row;
  logic [2:0]                 count;

  int n_pass  = 0;
  int n_total = 0;

  logic              vs [NCYC];
  logic [BITS_C-1:0] sd [NCYC][DIM];

  memc_deskew #(.BITS_C(BITS_C), .DIM(DIM), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready), .Cout(Cout),
    .out_row(out_row), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task clear_sched;
    for (int t = 0; t < NCYC; t++) begin
      vs[t] = 1'b0;
      for (int j = 0; j < DIM; j++) sd[t][j] = '0;
    end
  endtask

  task add_row(input int c, input int base);
    vs[c] = 1'b1;
    for (int j = 0; j < DIM; j++) sd[c][j] = BITS_C'(base + j);
  endtask

  task load_exp(input int c);
    for (int j = 0; j < DIM; j++) exp_row[j] = sd[c][j];
  endtask

  // Cin[j] at cycle t carries column j of the row that started at t-j.
  task step(input int t);
    in_valid = vs[t];
    for (int j = 0; j < DIM; j++) Cin[j] = (t >= j) ? sd[t-j][j] : '0;
    @(posedge clk);
    #1;
  endtask

  task do_clr;
    in_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else n_pass++;
    n_total++; if (out_row !== 3'd0) $display("FAIL reset_out_row got %0d exp 0", out_row); else n_pass++;
    n_total++; if (Cout !== '0) $display("FAIL reset_cout got %h exp 0", Cout); else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task test_single;
    clear_sched();
    do_clr();
    out_ready = 1'b1;
    add_row(0, 1);
    load_exp(0);
    for (int t = 0; t <= 9; t++) begin
      step(t);
      if (t == 6) begin
        n_total++; if (out_valid !== 1'b0) $display("FAIL single_early got %b exp 0", out_valid); else n_pass++;
      end
      if (t == 7) begin
        n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else n_pass++;
        n_total++; if (Cout !== exp_row) $display("FAIL single_cout got %h exp %h", Cout, exp_row); else n_pass++;
        n_total++; if (out_row !== 3'd0) $display("FAIL single_tag got %0d exp 0", out_row); else n_pass++;
      end
      if (t == 8) begin
        n_total++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL single_empty got v=%b c=%0d exp v=0 c=0", out_valid, count); else n_pass++;
      end
    end
  endtask

  task test_back_to_back;
    clear_sched();
    do_clr();
    out_ready = 1'b1;
    for (int r = 0; r <= 8; r++) add_row(r, 16 * r);
    for (int t = 0; t <= 17; t++) begin
      step(t);
      if (t >= 7 && t <= 15) begin
        load_exp(t - 7);
        n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid t=%0d got %b exp 1", t, out_valid); else n_pass++;
        n_total++; if (Cout !== exp_row) $display("FAIL b2b_cout t=%0d got %h exp %h", t, Cout, exp_row); else n_pass++;
        n_total++; if (out_row !== 3'((t - 7) % 8)) $display("FAIL b2b_tag t=%0d got %0d exp %0d", t, out_row, (t - 7) % 8); else n_pass++;
        n_total++; if (count !== 3'd1) $display("FAIL b2b_count t=%0d got %0d exp 1", t, count); else n_pass++;
      end
      if (t == 16) begin
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drained got %b exp 0", out_valid); else n_pass++;
      end
    end
  endtask

  task test_overflow;
    clear_sched();
    do_clr();
    for (int r = 0; r <= 4; r++) add_row(r, 256 * (r + 1));
    add_row(12, 16'h7000);
    for (int t = 0; t <= 20; t++) begin
      out_ready = (t >= 12);
      step(t);
      if (t == 10) begin
        n_total++; if (count !== 3'd4 || overflow !== 1'b0) $display("FAIL ovf_full got c=%0d o=%b exp c=4 o=0", count, overflow); else n_pass++;
      end
      if (t == 11) begin
        n_total++; if (count !== 3'd4 || overflow !== 1'b1) $display("FAIL ovf_set got c=%0d o=%b exp c=4 o=1", count, overflow); else n_pass++;
      end
      if (t >= 11 && t <= 14) begin
        load_exp(t - 11);
        n_total++; if (out_row !== 3'(t - 11) || Cout !== exp_row) $display("FAIL ovf_drain t=%0d got tag %0d data %h exp tag %0d data %h", t, out_row, Cout, t - 11, exp_row); else n_pass++;
        n_total++; if (count !== 3'(15 - t)) $display("FAIL ovf_count t=%0d got %0d exp %0d", t, count, 15 - t); else n_pass++;
      end
      if (t == 15 || t == 18) begin
        n_total++; if (out_valid !== 1'b0) $display("FAIL ovf_lost t=%0d got %b exp 0", t, out_valid); else n_pass++;
      end
      if (t == 19) begin
        load_exp(12);
        n_total++; if (out_valid !== 1'b1 || out_row !== 3'd5 || Cout !== exp_row) $display("FAIL ovf_next got v=%b tag %0d data %h exp v=1 tag 5 data %h", out_valid, out_row, Cout, exp_row); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else n_pass++;
      end
    end
  endtask

  task test_full_pop;
    clear_sched();
    do_clr();
    for (int r = 0; r <= 4; r++) add_row(r, 4096 + 32 * r);
    for (int t = 0; t <= 16; t++) begin
      out_ready = (t == 11 || t >= 13);
      step(t);
      if (t == 11 || t == 12) begin
        n_total++; if (count !== 3'd4 || overflow !== 1'b0) $display("FAIL fpop_count t=%0d got c=%0d o=%b exp c=4 o=0", t, count, overflow); else n_pass++;
        n_total++; if (out_row !== 3'd1) $display("FAIL fpop_head t=%0d got %0d exp 1", t, out_row); else n_pass++;
      end
      if (t >= 13 && t <= 15) begin
        load_exp(t - 11);
        n_total++; if (out_row !== 3'(t - 11) || Cout !== exp_row) $display("FAIL fpop_drain t=%0d got tag %0d data %h exp tag %0d data %h", t, out_row, Cout, t - 11, exp_row); else n_pass++;
        n_total++; if (count !== 3'(16 - t)) $display("FAIL fpop_dcount t=%0d got %0d exp %0d", t, count, 16 - t); else n_pass++;
      end
      if (t == 16) begin
        n_total++; if (count !== 3'd0) $display("FAIL fpop_empty got %0d exp 0", count); else n_pass++;
      end
    end
  endtask

  task test_negative;
    clear_sched();
    do_clr();
    out_ready = 1'b1;
    vs[0] = 1'b1;
    for (int j = 0; j < DIM; j++) sd[0][j] = (j % 2 == 0) ? 16'hFFFF : 16'h8000;
    load_exp(0);
    for (int t = 0; t <= 8; t++) begin
      step(t);
      if (t == 7) begin
        n_total++; if (Cout !== exp_row) $display("FAIL neg_cout got %h exp %h", Cout, exp_row); else n_pass++;
        n_total++; if ($signed(Cout[0]) !== -16'sd1 || $signed(Cout[1]) !== -16'sd32768) $display("FAIL neg_signed got %0d %0d exp -1 -32768", $signed(Cout[0]), $signed(Cout[1])); else n_pass++;
      end
    end
  endtask

  task test_clr_flight;
    bit ghost;
    clear_sched();
    do_clr();
    out_ready = 1'b0;
    for (int r = 0; r <= 4; r++) add_row(r, 64 * r);
    add_row(8, 16'h1000);
    add_row(9, 16'h2000);
    add_row(10, 16'h3000);
    add_row(12, 16'h4000);
    ghost = 1'b0;
    for (int t = 0; t <= 24; t++) begin
      clr = (t == 12);
      step(t);
      if (t == 11) begin
        n_total++; if (count !== 3'd4 || overflow !== 1'b1) $display("FAIL clr_pre got c=%0d o=%b exp c=4 o=1", count, overflow); else n_pass++;
      end
      if (t == 12) begin
        n_total++; if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) $display("FAIL clr_flush got v=%b c=%0d o=%b exp 0 0 0", out_valid, count, overflow); else n_pass++;
      end
      if (t > 12 && out_valid !== 1'b0) ghost = 1'b1;
    end
    clr = 1'b0;
    n_total++; if (ghost) $display("FAIL clr_ghost got 1 exp 0"); else n_pass++;
  endtask

  task test_rst_flight;
    bit ghost;
    clear_sched();
    do_clr();
    out_ready = 1'b0;
    add_row(0, 100);
    add_row(1, 200);
    add_row(6, 300);
    add_row(7, 400);
    for (int t = 0; t <= 8; t++) step(t);
    n_total++; if (count !== 3'd2) $display("FAIL rst_pre got %0d exp 2", count); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) $display("FAIL rst_async got v=%b c=%0d o=%b exp 0 0 0", out_valid, count, overflow); else n_pass++;
    n_total++; if (Cout !== '0 || out_row !== 3'd0) $display("FAIL rst_data got %h tag %0d exp 0", Cout, out_row); else n_pass++;
    #2 rst_n = 1'b1;
    #4;
    ghost = 1'b0;
    for (int t = 9; t <= 24; t++) begin
      step(t);
      if (out_valid !== 1'b0) ghost = 1'b1;
    end
    n_total++; if (ghost) $display("FAIL rst_ghost got 1 exp 0"); else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Cin       = '0;
    exp_row   = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_negative();
    test_clr_flight();
    test_rst_flight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
